// File: rtl/apu_pkg.sv
// Shared constants, header field layout and FSM state type for the pulse-channel
// register loader.
package apu_pkg;

   localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hA;

   localparam int unsigned TAG_MSB    = 7;
   localparam int unsigned TAG_LSB    = 4;
   localparam int unsigned RSV_BIT    = 3;
   localparam int unsigned COMMIT_BIT = 2;
   localparam int unsigned ADDR_MSB   = 1;
   localparam int unsigned ADDR_LSB   = 0;

   localparam logic [1:0] REG_DUTY  = 2'd0;
   localparam logic [1:0] REG_SWEEP = 2'd1;
   localparam logic [1:0] REG_LO    = 2'd2;
   localparam logic [1:0] REG_HI    = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_t;

   // A header is valid when its tag matches and the reserved bit is clear.
   function automatic logic hdr_valid(input logic [7:0] b, input logic [3:0] tag);
      return (b[TAG_MSB:TAG_LSB] == tag) && !b[RSV_BIT];
   endfunction

endpackage

// File: rtl/apu_holdoff_timer.sv
// Loadable down-counter: on i_load it takes CYCLES-1, then counts down to zero
// and holds there; o_expired_c is high whenever the count is zero.
module apu_holdoff_timer #(
   parameter int unsigned CYCLES = 32768
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   output logic o_expired_c
);

   localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= W'(CYCLES - 1);
      end else if (r_count != '0) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/apu_reg_loader.sv
// Parses header/data byte pairs into shadow register writes and commits them
// atomically to the pulse-channel registers, rate-limited by a holdoff timer.
module apu_reg_loader
   import apu_pkg::*;
#(
   parameter logic [3:0]  HEADER_TAG     = HEADER_TAG_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned COMMIT_HOLDOFF = 32768
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] reg_0,
   output logic [7:0] reg_1,
   output logic [7:0] reg_2,
   output logic [7:0] reg_3,
   output logic       change,
   output logic       commit_pending,
   output logic [7:0] frame_errors
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_addr;
   logic            r_commit;
   logic [3:0][7:0] r_shadow;
   logic [3:0][7:0] w_shadow_nxt;
   logic [3:0][7:0] r_reg;
   logic            r_change;
   logic            r_pending;
   logic [7:0]      r_frame_errors;

   logic w_hdr_ok;
   logic w_hdr_accept;
   logic w_hdr_reject;
   logic w_data_wr;
   logic w_timeout;
   logic w_to_expired;
   logic w_ho_expired;
   logic w_commit_req;
   logic w_commit_now;

   assign w_hdr_ok = hdr_valid(rx_data, HEADER_TAG);

   // Timeout counter expires on the last cycle a data byte is still accepted.
   apu_holdoff_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_hdr_accept),
      .o_expired_c (w_to_expired)
   );

   apu_holdoff_timer #(.CYCLES(COMMIT_HOLDOFF)) u_holdoff (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_commit_now),
      .o_expired_c (w_ho_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (rx_valid && w_hdr_ok) w_state_nxt = DATA;
         DATA: if (rx_valid || w_to_expired) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A byte on the expiry cycle wins over the timeout.
   always_comb begin
      w_hdr_accept = 1'b0;
      w_hdr_reject = 1'b0;
      w_data_wr    = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_valid) begin
               w_hdr_accept = w_hdr_ok;
               w_hdr_reject = !w_hdr_ok;
            end
         end
         DATA: begin
            if (rx_valid)          w_data_wr = 1'b1;
            else if (w_to_expired) w_timeout = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_commit_req = w_data_wr && r_commit;
   assign w_commit_now = w_ho_expired && (w_commit_req || r_pending);

   // Commits copy the shadows including any byte captured on the same edge.
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (w_data_wr) w_shadow_nxt[r_addr] = rx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr         <= '0;
         r_commit       <= 1'b0;
         r_shadow       <= '0;
         r_reg          <= '0;
         r_change       <= 1'b0;
         r_pending      <= 1'b0;
         r_frame_errors <= '0;
      end else begin
         if (w_hdr_accept) begin
            r_addr   <= rx_data[ADDR_MSB:ADDR_LSB];
            r_commit <= rx_data[COMMIT_BIT];
         end
         r_shadow <= w_shadow_nxt;
         if (w_commit_now) begin
            r_reg     <= w_shadow_nxt;
            r_change  <= ~r_change;
            r_pending <= 1'b0;
         end else if (w_commit_req) begin
            r_pending <= 1'b1;
         end
         if ((w_hdr_reject || w_timeout) && (r_frame_errors != 8'hFF)) begin
            r_frame_errors <= r_frame_errors + 8'd1;
         end
      end
   end

   assign reg_0          = r_reg[REG_DUTY];
   assign reg_1          = r_reg[REG_SWEEP];
   assign reg_2          = r_reg[REG_LO];
   assign reg_3          = r_reg[REG_HI];
   assign change         = r_change;
   assign commit_pending = r_pending;
   assign frame_errors   = r_frame_errors;

endmodule
